// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding, line constants and counter widths for the USB TX sequencer
package usb_tx_pkg;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int STUFF_LEN = 6;
  localparam int EOP_SE0_BITS = 2;
  localparam int BIT_W = 3;
  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [BIT_W-1:0] EOP_LAST = BIT_W'(EOP_SE0_BITS - 1);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
endpackage

// File: rtl/usb_tx_seq_if.sv
// usb_tx_seq_if: SIE byte handshake (DataOut_i, TxValid_i from SIE; TxReady_o back to SIE)
interface usb_tx_seq_if;
  logic [7:0] DataOut_i;
  logic TxValid_i;
  logic TxReady_o;
  modport master(output DataOut_i, TxValid_i, input TxReady_o);
  modport slave(input DataOut_i, TxValid_i, output TxReady_o);
endinterface

// File: rtl/usb_tx_stuff_ctr.sv
// usb_tx_stuff_ctr: consecutive-ones counter; stuff_req flags the bit that completes a STUFF_LEN run (clk, rst, bit_en, din, clr -> stuff_req)
module usb_tx_stuff_ctr
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_en,
  input  logic din,
  input  logic clr,
  output logic stuff_req
);
  logic [ONES_W-1:0] ones;
  always_ff @(posedge clk)
    if (!rst || clr) ones <= '0;
    else if (bit_en) ones <= din ? ones + ONES_W'(1) : '0;
  assign stuff_req = bit_en & din & (ones == ONES_W'(STUFF_LEN - 1));
endmodule

// File: rtl/usb_tx_seq.sv
// usb_tx_seq: USB TX sequencer emitting SYNC, stuffed LSB-first data and EOP per bit_en (clk, rst, bit_en, sie handshake -> bit_o, se0_o, oe_o)
module usb_tx_seq
  import usb_tx_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en,
  usb_tx_seq_if.slave  sie,
  output logic         bit_o,
  output logic         se0_o,
  output logic         oe_o
);
  state_t state, state_n;
  logic [7:0] hold, hold_n;
  logic [BIT_W-1:0] bit_cnt, cnt_n;
  logic bit_n, se0_n, oe_n, ready, cnt_en, din, clr, stuff_req;
  assign cnt_en = bit_en & (state == SYNC || state == DATA || state == STUFF);
  assign din = (state != STUFF) & hold[0];
  assign clr = bit_en & (state == IDLE);
  assign sie.TxReady_o = ready & rst;
  usb_tx_stuff_ctr u_stuff (
    .clk(clk), .rst(rst), .bit_en(cnt_en), .din(din), .clr(clr), .stuff_req(stuff_req)
  );
  always_comb begin
    state_n = state;
    hold_n = hold;
    cnt_n = bit_cnt;
    bit_n = bit_o;
    se0_n = se0_o;
    oe_n = oe_o;
    ready = 1'b0;
    if (bit_en)
      case (state)
        IDLE: begin
          bit_n = sie.TxValid_i ? SYNC_PATTERN[0] : 1'b1;
          oe_n = sie.TxValid_i;
          se0_n = 1'b0;
          if (sie.TxValid_i) begin
            state_n = SYNC;
            hold_n = SYNC_PATTERN >> 1;
            cnt_n = BIT_W'(1);
          end
        end
        SYNC, DATA: begin
          bit_n = hold[0];
          hold_n = hold >> 1;
          cnt_n = bit_cnt + BIT_W'(1);
          if (stuff_req) state_n = STUFF;
          else if (bit_cnt == BIT_W'(7)) begin
            ready = sie.TxValid_i;
            state_n = sie.TxValid_i ? DATA : EOP_SE0;
            hold_n = sie.TxValid_i ? sie.DataOut_i : hold_n;
          end
        end
        STUFF: begin
          bit_n = 1'b0;
          ready = (bit_cnt == '0) & sie.TxValid_i;
          state_n = (bit_cnt != '0 || sie.TxValid_i) ? DATA : EOP_SE0;
          hold_n = ready ? sie.DataOut_i : hold;
        end
        EOP_SE0: begin
          bit_n = 1'b0;
          se0_n = 1'b1;
          cnt_n = bit_cnt + BIT_W'(1);
          state_n = (bit_cnt == EOP_LAST) ? EOP_J : EOP_SE0;
        end
        EOP_J: begin
          bit_n = 1'b1;
          se0_n = 1'b0;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      hold <= '0;
      bit_cnt <= '0;
      bit_o <= 1'b1;
      se0_o <= 1'b0;
      oe_o <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      bit_cnt <= cnt_n;
      bit_o <= bit_n;
      se0_o <= se0_n;
      oe_o <= oe_n;
    end
endmodule

// File: tb/tb_usb_tx_seq.sv
// tb_usb_tx_seq: randomized scoreboard bench for usb_tx_seq against a bit-list reference model
module tb_usb_tx_seq;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int RUN_LEN = 6;
  localparam int SE0_LEN = 2;
  logic clk = 1'b0;
  logic rst, bit_en;
  logic bit_o, se0_o, oe_o;
  usb_tx_seq_if sie();
  usb_tx_seq dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .sie(sie),
    .bit_o(bit_o), .se0_o(se0_o), .oe_o(oe_o)
  );
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  logic [2:0] exp_q[$];
  logic [7:0] pkt[$];
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic model();
    logic [7:0] s = SYNC_BYTE;
    logic [7:0] d;
    bit bits[$];
    int run = 0;
    for (int i = 0; i < 8; i++) bits.push_back(s[i]);
    foreach (pkt[j]) begin
      d = pkt[j];
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    end
    foreach (bits[i]) begin
      exp_q.push_back({2'b10, bits[i]});
      run = bits[i] ? run + 1 : 0;
      if (run == RUN_LEN) begin
        exp_q.push_back(3'b100);
        run = 0;
      end
    end
    repeat (SE0_LEN) exp_q.push_back(3'b110);
    exp_q.push_back(3'b101);
  endtask
  logic [2:0] last_exp = 3'b001;
  bit be_q = 1'b0, rst_q = 1'b1, avail_q = 1'b0, started = 1'b0;
  always @(negedge clk) begin
    logic [2:0] e;
    if (started) begin
      if (!rst_q) begin
        last_exp = 3'b001;
        check("reset_state", {sie.TxReady_o, oe_o, se0_o, bit_o}, 4'b0001);
      end else if (be_q) begin
        if (avail_q && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          pops++;
        end else e = 3'b001;
        check("line_bit", {oe_o, se0_o, bit_o}, e);
        last_exp = e;
      end else check("hold_no_bit_en", {oe_o, se0_o, bit_o}, last_exp);
      if (sie.TxReady_o) check("txready_on_bit_en", bit_en & rst, 1);
    end
    started = 1'b1;
    rst_q = rst;
    be_q = bit_en & rst;
    avail_q = exp_q.size() != 0;
  end
  task automatic drive(input bit want, input logic [7:0] cur, inout int stall);
    bit_en = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (stall > 0) stall--;
    sie.TxValid_i = bit_en ? want : 1'($urandom);
    sie.DataOut_i = bit_en ? cur : 8'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      bit_en = $urandom_range(0, 3) != 0;
      sie.TxValid_i = bit_en ? 1'b0 : 1'($urandom);
      sie.DataOut_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic abort();
    rst = 1'b0;
    bit_en = 1'($urandom);
    sie.TxValid_i = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    repeat (2) begin
      bit_en = 1'($urandom);
      sie.TxValid_i = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bit_en = 1'b0;
    sie.TxValid_i = 1'b0;
  endtask
  task automatic send(input int abort_at, input int freeze_at, input bit chk_gap);
    int k = 0, budget = 0, stall = 0, nb = 0;
    int be_idx[$];
    bit want = 1'b1;
    logic [7:0] cur;
    model();
    cur = pkt[0];
    pops = 0;
    do begin
      if (budget == freeze_at) stall = 5;
      drive(want, cur, stall);
      @(negedge clk);
      if (bit_en) nb++;
      if (sie.TxReady_o) begin
        k++;
        be_idx.push_back(nb);
      end
      @(posedge clk);
      #1;
      if (k < pkt.size()) cur = pkt[k];
      else want = 1'b0;
      budget++;
      if (abort_at > 0 && pops >= abort_at) begin
        abort();
        return;
      end
    end while (exp_q.size() != 0 && budget < 4000);
    check("packet_done_in_budget", budget < 4000, 1);
    check("txready_count", k, pkt.size());
    if (chk_gap) check("txready_gap", (be_idx.size() == 2) ? be_idx[1] - be_idx[0] : -1, 8);
  endtask
  initial begin
    rst = 1'b0;
    bit_en = 1'b0;
    sie.TxValid_i = 1'b0;
    sie.DataOut_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    pkt = '{8'h00};
    send(0, -1, 1'b0);
    idle(3);
    pkt = '{8'hFF};
    send(0, -1, 1'b0);
    idle(2);
    pkt = '{8'hA5, 8'h3C};
    send(0, -1, 1'b1);
    pkt = '{8'hFC};
    send(0, -1, 1'b0);
    idle(1);
    pkt = '{8'hFC, 8'h01};
    send(0, -1, 1'b0);
    idle(2);
    pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
    send(12, -1, 1'b0);
    pkt = '{8'h5A};
    send(0, -1, 1'b0);
    idle(2);
    pkt = '{8'hFF, 8'h0F};
    send(0, 14, 1'b0);
    for (int p = 0; p < 12; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 4)) pkt.push_back(8'($urandom));
      send((p == 7) ? 20 : 0, (p % 3 == 0) ? 9 : -1, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
